// File: rtl/rf_wb_queue_if.sv
// Writeback queue bus: producer handshake, register-file write port and bypass taps.
interface rf_wb_queue_if #(
  parameter int unsigned CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_reg;
  logic [31:0]   in_data;
  logic [3:0]    write_reg;
  logic [31:0]   write_data;
  logic          rf_we;
  logic [3:0]    read_rega;
  logic [3:0]    read_regb;
  logic          byp_hit_a;
  logic [31:0]   byp_data_a;
  logic          byp_hit_b;
  logic [31:0]   byp_data_b;
  logic          pending;
  logic [CW-1:0] count;

  // Producer / reader side
  modport master (
    output in_valid, in_reg, in_data, read_rega, read_regb,
    input  in_ready, write_reg, write_data, rf_we,
    input  byp_hit_a, byp_data_a, byp_hit_b, byp_data_b, pending, count
  );

  // Queue side
  modport slave (
    input  in_valid, in_reg, in_data, read_rega, read_regb,
    output in_ready, write_reg, write_data, rf_we,
    output byp_hit_a, byp_data_a, byp_hit_b, byp_data_b, pending, count
  );
endinterface

// File: rtl/rf_wb_queue.sv
// In-order writeback FIFO driving a rising-edge-strobed register file write port,
// with a youngest-match bypass of entries that have not yet retired.
module rf_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = 2,
  parameter int unsigned CW    = 3
) (
  input logic          clk,
  input logic          rst,
  rf_wb_queue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  logic [3:0]    mem_reg  [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] head_q, tail_q, head_nxt_c, idx_c;
  logic [CW-1:0] count_q;
  state_t        state_q, state_d;
  logic          rf_we_q, rf_we_d;
  logic [3:0]    write_reg_q, write_reg_d;
  logic [31:0]   write_data_q, write_data_d;
  logic          push_c, pop_c;
  logic          hit_a_c, hit_b_c;
  logic [31:0]   data_a_c, data_b_c;

  // R0 results are accepted but never enqueued
  assign push_c     = bus.in_valid && bus.in_ready && (bus.in_reg != 4'd0);
  assign pop_c      = (state_q == HOLD);
  assign head_nxt_c = head_q + PW'(1);

  assign bus.in_ready   = (count_q < CW'(DEPTH));
  assign bus.pending    = (count_q != '0);
  assign bus.count      = count_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.byp_hit_a  = hit_a_c;
  assign bus.byp_data_a = data_a_c;
  assign bus.byp_hit_b  = hit_b_c;
  assign bus.byp_data_b = data_b_c;

  // Entry storage; contents are don't-care until counted as valid
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_reg[tail_q]  <= bus.in_reg;
      mem_data[tail_q] <= bus.in_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_c) tail_q <= tail_q + PW'(1);
      if (pop_c)  head_q <= head_nxt_c;
      count_q <= count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  // Write sequencer state and registered write-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rf_we_q      <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      rf_we_q      <= rf_we_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Next state: SETUP loads the head, STROBE raises rf_we, HOLD keeps data and pops
  always_comb begin
    state_d      = state_q;
    rf_we_d      = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d      = SETUP;
          write_reg_d  = mem_reg[head_q];
          write_data_d = mem_data[head_q];
        end
      end
      SETUP: begin
        state_d = STROBE;
        rf_we_d = 1'b1;
      end
      STROBE: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (count_q > CW'(1)) begin
          state_d      = SETUP;
          write_reg_d  = mem_reg[head_nxt_c];
          write_data_d = mem_data[head_nxt_c];
        end else if (push_c) begin
          // The entry arriving on the pop edge is not in storage yet
          state_d      = SETUP;
          write_reg_d  = bus.in_reg;
          write_data_d = bus.in_data;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bypass: scan oldest to youngest so the youngest match overrides
  always_comb begin
    hit_a_c  = 1'b0;
    data_a_c = '0;
    hit_b_c  = 1'b0;
    data_b_c = '0;
    idx_c    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx_c = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((bus.read_rega != 4'd0) && (mem_reg[idx_c] == bus.read_rega)) begin
          hit_a_c  = 1'b1;
          data_a_c = mem_data[idx_c];
        end
        if ((bus.read_regb != 4'd0) && (mem_reg[idx_c] == bus.read_regb)) begin
          hit_b_c  = 1'b1;
          data_b_c = mem_data[idx_c];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Scoreboard bench for rf_wb_queue: queue-based reference model, strobe monitor,
// bypass/occupancy checks every cycle, directed scenarios then random traffic.
module tb_rf_wb_queue;

  typedef struct packed {
    logic [3:0]  r;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rst;

  rf_wb_queue_if #(.CW(3)) bus ();

  rf_wb_queue #(.DEPTH(4), .PW(2), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  ent_t        pend[$];      // entries the queue should still hold
  ent_t        sb[$];        // writes the register file has yet to see
  logic [31:0] rf_model [16];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ncyc     = 0;
  int          exp_strobe = -1;
  bit          pop_pending = 0;
  logic        prev_we = 0;
  logic [3:0]  prev_reg = 0, st_reg = 0;
  logic [31:0] prev_data = 0, st_data = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Youngest pending entry for an address; R0 never matches
  function automatic void model_byp(input logic [3:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (pend[i]) begin
      if (a != 4'd0 && pend[i].r == a) begin
        hit = 1'b1;
        d   = pend[i].d;
      end
    end
  endfunction

  // Register file behaviour: capture on the strobe's rising edge
  always @(posedge bus.rf_we) rf_model[bus.write_reg] = bus.write_data;

  // Reference model update at each active edge
  always @(posedge clk) begin
    bit was_empty, popped;
    ent_t e;
    if (rst) begin
      pend.delete();
      sb.delete();
      exp_strobe  = -1;
      pop_pending = 0;
    end else begin
      was_empty = (pend.size() == 0);
      popped    = 0;
      if (pop_pending) begin
        if (pend.size() > 0) void'(pend.pop_front());
        pop_pending = 0;
        popped      = 1;
      end
      if (bus.in_valid && bus.in_ready && bus.in_reg != 4'd0) begin
        e.r = bus.in_reg;
        e.d = bus.in_data;
        pend.push_back(e);
        sb.push_back(e);
      end
      // Back-to-back writes are 3 cycles apart; a fresh write strobes 2 cycles after accept
      if (pend.size() > 0) begin
        if (popped)         exp_strobe = ncyc + 2;
        else if (was_empty) exp_strobe = ncyc + 3;
      end
    end
  end

  // Monitor: strobe timing/order, address/data stability, bypass and occupancy
  always @(negedge clk) begin
    logic rise, h;
    logic [31:0] d;
    ent_t e;
    ncyc++;
    if (rst) begin
      prev_we = 0;
    end else begin
      rise = bus.rf_we && !prev_we;
      if (rise) chk("strobe_cycle", ncyc, exp_strobe);
      else if (ncyc == exp_strobe) chk("strobe_missing", bus.rf_we, 1);
      if (rise) begin
        exp_strobe = -1;
        if (sb.size() == 0) begin
          chk("write_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("write_reg", bus.write_reg, e.r);
          chk("write_data", bus.write_data, e.d);
          chk("setup_reg_stable", prev_reg, bus.write_reg);
          chk("setup_data_stable", prev_data, bus.write_data);
        end
        st_reg  = bus.write_reg;
        st_data = bus.write_data;
      end
      if (prev_we && !bus.rf_we) begin
        chk("hold_reg_stable", bus.write_reg, st_reg);
        chk("hold_data_stable", bus.write_data, st_data);
        pop_pending = 1;
      end
      chk("count", bus.count, pend.size());
      chk("in_ready", bus.in_ready, pend.size() < 4);
      chk("pending", bus.pending, pend.size() != 0);
      model_byp(bus.read_rega, h, d);
      chk("byp_hit_a", bus.byp_hit_a, h);
      chk("byp_data_a", bus.byp_data_a, d);
      model_byp(bus.read_regb, h, d);
      chk("byp_hit_b", bus.byp_hit_b, h);
      chk("byp_data_b", bus.byp_data_b, d);
      prev_we = bus.rf_we;
    end
    prev_reg  = bus.write_reg;
    prev_data = bus.write_data;
  end

  // Offer one result and hold it until accepted
  task automatic send(input logic [3:0] r, input logic [31:0] d);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_reg   = r;
    bus.in_data  = d;
    while (waited < 100) begin
      @(posedge clk);
      if (bus.in_ready) break;
      waited++;
    end
    if (waited >= 100) chk("send_timeout", waited, 0);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (waited < 300) begin
      @(negedge clk);
      if (pend.size() == 0 && !bus.rf_we) break;
      waited++;
    end
    if (waited >= 300) chk("drain_timeout", waited, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    logic [31:0] d;
    clk = 0;
    rst = 1;
    bus.in_valid  = 0;
    bus.in_reg    = 0;
    bus.in_data   = 0;
    bus.read_rega = 0;
    bus.read_regb = 0;
    foreach (rf_model[i]) rf_model[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_write_reg", bus.write_reg, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_pending", bus.pending, 0);
    rst = 0;
    @(posedge clk);
    #1;

    // Single write
    send(4'd3, 32'hDEADBEEF);
    wait_idle();
    chk("rf_r3", rf_model[3], 32'hDEADBEEF);

    // Fill and drain with back-pressure
    for (int i = 1; i <= 6; i++) send(4'(i), 32'(i));
    wait_idle();
    for (int i = 1; i <= 6; i++) chk("rf_fill", rf_model[i], 32'(i));

    // Bypass youngest-wins on a repeated destination
    bus.read_rega = 4'd5;
    bus.read_regb = 4'd5;
    send(4'd5, 32'h11);
    send(4'd5, 32'h22);
    @(negedge clk);
    chk("byp_young_a", bus.byp_data_a, 32'h22);
    wait_idle();
    chk("rf_r5", rf_model[5], 32'h22);

    // R0 filter
    bus.read_rega = 4'd0;
    bus.read_regb = 4'd0;
    send(4'd0, 32'hFFFFFFFF);
    repeat (6) @(posedge clk);
    #1;
    chk("r0_count", bus.count, 0);
    chk("r0_hit_a", bus.byp_hit_a, 0);
    chk("rf_r0", rf_model[0], 0);

    // Reset during STROBE with two entries queued
    bus.read_rega = 4'd7;
    bus.read_regb = 4'd8;
    send(4'd7, 32'h77);
    send(4'd8, 32'h88);
    waited = 0;
    while (waited < 50) begin
      @(negedge clk);
      if (bus.rf_we) break;
      waited++;
    end
    if (waited >= 50) chk("strobe_timeout", waited, 0);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_rf_we", bus.rf_we, 0);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_pending", bus.pending, 0);
    chk("mid_rst_hit_a", bus.byp_hit_a, 0);
    chk("mid_rst_hit_b", bus.byp_hit_b, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("rf_r7_written", rf_model[7], 32'h77);
    chk("rf_r8_dropped", rf_model[8], 0);

    // Random traffic with random bypass probes
    bus.in_valid = 0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.in_valid && $urandom_range(0, 2) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_reg   = 4'($urandom_range(0, 7));
        d            = $urandom;
        bus.in_data  = d;
      end
      bus.read_rega = 4'($urandom_range(0, 7));
      bus.read_regb = 4'($urandom_range(0, 7));
      @(posedge clk);
      if (bus.in_valid && bus.in_ready) begin
        #1;
        bus.in_valid = 1'b0;
      end else begin
        #1;
      end
    end
    bus.in_valid = 1'b0;
    wait_idle();
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
Writeback sequencer and initiator for the 16x32 register file's write port. It accepts ALU/memory results over a valid/ready handshake and buffers them in a small in-order FIFO. It drives write_reg/write_data/rf_we toward the register file, which captures on the rising edge of rf_we. It also gives the read side a bypass of still-pending results, so operand reads see the youngest value.

Parameters:
DEPTH, 4, number of queued writeback entries (power of 2, >=2)
PW, 2, pointer width, log2(DEPTH)
CW, 3, occupancy counter width, log2(DEPTH)+1

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  producer offers a result this cycle
in_ready  output  1  queue can accept (count < DEPTH)
in_reg  input  4  destination register number
in_data  input  32  result data
write_reg  output  4  register file write address
write_data  output  32  register file write data
rf_we  output  1  register file write strobe; the register file writes on its rising edge
read_rega  input  4  operand A address, same value the register file sees
read_regb  input  4  operand B address
byp_hit_a  output  1  a pending entry matches read_rega
byp_data_a  output  32  youngest pending data for read_rega
byp_hit_b  output  1  same for read_regb
byp_data_b  output  32  same for read_regb
pending  output  1  count != 0
count  output  CW  occupied entries

Behaviour:
- One clock. Reset is asynchronous and active-high.
- While rst is high: rf_we=0, write_reg=0, write_data=0, count=0, pointers=0, state=IDLE, in_ready=1, pending=0, byp_hit_a/b=0.
- Accept: an entry is accepted when in_valid && in_ready at a rising clk edge. The entry is written at the tail, and the tail pointer wraps modulo DEPTH.
- R0 filter: an accepted entry with in_reg==0 is consumed and discarded. It does not change count and produces no rf_we pulse.
- Write FSM, all outputs registered:
  - IDLE -> SETUP when count!=0.
  - SETUP: write_reg/write_data loaded from the head entry; rf_we=0.
  - STROBE: rf_we=1; address and data held.
  - HOLD: rf_we=0; address and data held. Head is popped at the end of HOLD.
  - HOLD -> SETUP if count after the pop is nonzero, else HOLD -> IDLE.
- Timing:
  - Address and data are stable one full cycle before and one full cycle after the rf_we rising edge.
  - Throughput is one write per 3 cycles.
  - Latency: accept at edge E0 gives SETUP in cycle E1-E2, rf_we high in cycle E2-E3, and the pop at E4.
- Simultaneous accept and pop in the same cycle: count is unchanged and both pointers advance.
- in_ready is derived from the registered count only. When full, no accept occurs even if a pop happens that cycle.
- Bypass (combinational):
  - Search all valid entries from head to tail. The youngest match wins.
  - The head entry stays visible until its pop, including during SETUP, STROBE and HOLD.
  - Address 0 never hits.
  - On a miss, byp_data = 0.
  - After the pop the register file already holds the value, so no coherence gap exists.
- Reset mid-operation:
  - rf_we drops immediately and the queue is flushed.
  - If reset arrives in SETUP, no write occurs.
  - If reset arrives in STROBE or HOLD, the write has already happened, because the rising edge has passed.
- Entries always retire in FIFO order. Writes are never reordered, merged or duplicated.

Test Plan:
- Reset: assert rst mid-cycle -> rf_we=0, count=0, in_ready=1, pending=0, byp_hit_a/b=0 immediately, without waiting for a clock.
- Single write: accept R3=0xDEADBEEF at E0 -> write_reg=3 and write_data=0xDEADBEEF from E1, rf_we high exactly during E2-E3, count=0 after E4; the register file then reads R3=0xDEADBEEF.
- Fill and drain: offer R1..R6 with data 0x1..0x6 every cycle -> in_ready=0 while count=4; six rf_we pulses in order R1..R6 spaced 3 cycles apart; each rising edge sees the matching data; no drops.
- Bypass: accept R5=0x11 then R5=0x22 with read_rega=5 and read_regb=5 -> both hits =1 with data 0x22 until the second entry pops, then both hits =0.
- R0 filter: accept reg 0 with data 0xFFFFFFFF -> count stays 0, no rf_we pulse, byp_hit_a=0 for read_rega=0.
- Reset in STROBE with 2 entries queued -> rf_we falls at once, count=0; after release no further pulses occur until a new accept.
